jk_tmr_vote_monitor: RTL and testbench
======================================

Name: jk_tmr_vote_monitor

Overview:
- Downstream consumer of the three JK flip-flop implementations (SR-based, D-based, T-based).
- Each cycle it takes the three Q outputs as redundant lanes and produces a registered majority-voted Q.
- Tracks per-lane disagreement, declares persistently disagreeing lanes failed, and degrades gracefully through a 3-state health FSM.
- Lane a = SR-based Q, lane b = D-based Q, lane c = T-based Q.

Parameters:
- CNT_W, 8: width of each per-lane saturating mismatch counter.
- FAULT_THRESH, 3: consecutive disagreeing cycles that declare a fault. Legal range 1..15.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high.
- en  in  1  sample enable; when low, all state is frozen.
- q_a  in  1  Q from the SR-based JK.
- q_b  in  1  Q from the D-based JK.
- q_c  in  1  Q from the T-based JK.
- q_vote  out  1  registered voted Q.
- valid  out  1  q_vote was updated from a sample this cycle.
- any_mismatch  out  1  registered disagreement/split flag.
- lane_fail  out  3  sticky failed-lane flags; bit0=a, bit1=b, bit2=c.
- mis_cnt_a  out  CNT_W  disagreement count for lane a.
- mis_cnt_b  out  CNT_W  disagreement count for lane b.
- mis_cnt_c  out  CNT_W  disagreement count for lane c.
- state  out  2  health state: 00 NOMINAL, 01 DEGRADED, 10 FAILED.

Behaviour:
- Reset (synchronous, active-high) takes priority over everything, including mid-operation. At the next edge:
  - q_vote, valid, any_mismatch, lane_fail, all mis_cnt_*, and internal consecutive counters go to 0.
  - state goes to NOMINAL.
- en=0: nothing changes except valid<=0 and any_mismatch<=0. Consecutive counters are held, not cleared.
- Latency: all outputs are registered and reflect the inputs sampled at the previous edge (1 cycle).
- maj = (q_a&q_b)|(q_a&q_c)|(q_b&q_c).
- NOMINAL, en=1:
  - q_vote<=maj; valid<=1.
  - Lane i disagrees when q_i!=maj. At most one lane can disagree per cycle.
  - On disagreement: mis_cnt_i increments, saturating at 2^CNT_W-1. consec_i increments; consec of the other lanes clears. any_mismatch<=1.
  - With no disagreement, all consec clear and any_mismatch<=0.
  - When consec_i reaches FAULT_THRESH, lane_fail[i]<=1 and state<=DEGRADED at that edge. q_vote in that same cycle is still maj.
- DEGRADED, en=1 (the two healthy lanes are used):
  - Healthy lanes equal: q_vote<=their value; valid<=1; split counter clears; any_mismatch<=0.
  - Healthy lanes differ (split): q_vote holds; valid<=1; any_mismatch<=1; split counter increments.
  - Split counter reaching FAULT_THRESH: state<=FAILED.
  - No per-lane fault detection or mis_cnt updates occur in DEGRADED. lane_fail is unchanged.
- FAILED: q_vote frozen at its last value; valid<=0 permanently; any_mismatch<=1. Exit only via reset.
- lane_fail and the counters are sticky until reset.

Test Plan (CNT_W=8, FAULT_THRESH=3):
- Reset, then q_a=q_b=q_c toggling 0,1,1,0 with en=1 -> q_vote 0,1,1,0 one cycle late; valid=1; all counts 0; state=00.
- q_b inverted for 2 cycles, then agrees -> mis_cnt_b=2, lane_fail=000, any_mismatch high for 2 cycles, q_vote equals q_a throughout.
- q_a=q_b=0, q_c=1 held 3 cycles -> lane_fail=100, state=01 after 3rd edge, mis_cnt_c=3, q_vote=0.
- In DEGRADED (c failed), q_a=1, q_b=0 for 2 cycles then agree -> q_vote held, any_mismatch=1 for 2 cycles, state stays 01. Hold the split 3 cycles -> state=10, valid=0, q_vote frozen.
- NOMINAL, q_a disagrees 2 cycles then agrees 1, repeated 130 times -> mis_cnt_a saturates at 255, lane_fail=000. Deassert en mid-pattern -> counters freeze, valid=0.
- Reset asserted while in state 01 with counts nonzero -> all outputs 0 and state=00 at the next edge. Normal voting resumes the cycle after reset deasserts.

Source files
------------

// File: rtl/jk_tmr_vote_monitor.sv
// Triple-redundant vote monitor for the SR/D/T-based JK flip-flop Q outputs.
// It produces a registered majority Q, keeps per-lane disagreement statistics and tracks health.
module jk_tmr_vote_monitor #(
  parameter int CNT_W        = 8,
  parameter int FAULT_THRESH = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             q_a,
  input  logic             q_b,
  input  logic             q_c,
  output logic             q_vote,
  output logic             valid,
  output logic             any_mismatch,
  output logic [2:0]       lane_fail,
  output logic [CNT_W-1:0] mis_cnt_a,
  output logic [CNT_W-1:0] mis_cnt_b,
  output logic [CNT_W-1:0] mis_cnt_c,
  output logic [1:0]       state
);

  typedef enum logic [1:0] {
    NOMINAL  = 2'b00,
    DEGRADED = 2'b01,
    FAILED   = 2'b10
  } health_t;

  localparam int              CON_W   = 4;
  localparam logic [CON_W-1:0] THRESH  = CON_W'(FAULT_THRESH);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  health_t          state_q, state_d;
  logic             q_vote_d, valid_d, mm_d;
  logic [2:0]       fail_d;
  logic [CNT_W-1:0] mis_q   [3];
  logic [CNT_W-1:0] mis_d   [3];
  logic [CON_W-1:0] con_q   [3];
  logic [CON_W-1:0] con_d   [3];
  logic [CON_W-1:0] split_q, split_d;
  logic [2:0]       lanes;
  logic             maj;
  logic             h0, h1;

  assign lanes = {q_c, q_b, q_a};
  assign maj   = (q_a & q_b) | (q_a & q_c) | (q_b & q_c);

  // NOTE: every signal written here is given a default first, so no path leaves
  // a value unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    q_vote_d = q_vote;
    valid_d  = 1'b0;
    mm_d     = 1'b0;
    fail_d   = lane_fail;
    mis_d    = mis_q;
    con_d    = con_q;
    split_d  = split_q;
    h0       = q_a;
    h1       = q_b;

    // The surviving pair skips whichever lane has been declared failed.
    if (lane_fail[0]) begin
      h0 = q_b;
      h1 = q_c;
    end else if (lane_fail[1]) begin
      h0 = q_a;
      h1 = q_c;
    end

    if (en) begin
      unique case (state_q)
        NOMINAL: begin
          q_vote_d = maj;
          valid_d  = 1'b1;
          for (int i = 0; i < 3; i++) begin
            if (lanes[i] != maj) begin
              mm_d = 1'b1;
              if (mis_q[i] != CNT_MAX) mis_d[i] = mis_q[i] + CNT_W'(1);
              con_d[i] = con_q[i] + CON_W'(1);
              if (con_d[i] == THRESH) begin
                fail_d[i] = 1'b1;
                state_d   = DEGRADED;
              end
            end else begin
              con_d[i] = '0;
            end
          end
        end
        DEGRADED: begin
          valid_d = 1'b1;
          if (h0 == h1) begin
            q_vote_d = h0;
            split_d  = '0;
          end else begin
            mm_d    = 1'b1;
            split_d = split_q + CON_W'(1);
            if (split_d == THRESH) state_d = FAILED;
          end
        end
        default: begin
          valid_d = 1'b0;
          mm_d    = 1'b1;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values computed above.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= NOMINAL;
      q_vote       <= 1'b0;
      valid        <= 1'b0;
      any_mismatch <= 1'b0;
      lane_fail    <= '0;
      split_q      <= '0;
      // NOTE: the small counter arrays are explicitly cleared because their
      // values are architecturally visible after reset.
      for (int i = 0; i < 3; i++) begin
        mis_q[i] <= '0;
        con_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      q_vote       <= q_vote_d;
      valid        <= valid_d;
      any_mismatch <= mm_d;
      lane_fail    <= fail_d;
      split_q      <= split_d;
      for (int i = 0; i < 3; i++) begin
        mis_q[i] <= mis_d[i];
        con_q[i] <= con_d[i];
      end
    end
  end

  assign mis_cnt_a = mis_q[0];
  assign mis_cnt_b = mis_q[1];
  assign mis_cnt_c = mis_q[2];
  assign state     = state_q;

endmodule

// File: tb/tb_jk_tmr_vote_monitor.sv
// Scoreboard bench for jk_tmr_vote_monitor: a behavioural model pushes expected outputs
// as each sample is driven, and they are popped and compared one edge later.
module tb_jk_tmr_vote_monitor;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en = 1'b0;
  logic       q_a = 1'b0, q_b = 1'b0, q_c = 1'b0;
  logic       q_vote, valid, any_mismatch;
  logic [2:0] lane_fail;
  logic [7:0] mis_cnt_a, mis_cnt_b, mis_cnt_c;
  logic [1:0] state;

  int n_vec = 0;
  int n_mis = 0;
  int cyc   = 0;

  jk_tmr_vote_monitor #(.CNT_W(8), .FAULT_THRESH(3)) dut (
    .clk(clk), .reset(reset), .en(en),
    .q_a(q_a), .q_b(q_b), .q_c(q_c),
    .q_vote(q_vote), .valid(valid), .any_mismatch(any_mismatch),
    .lane_fail(lane_fail),
    .mis_cnt_a(mis_cnt_a), .mis_cnt_b(mis_cnt_b), .mis_cnt_c(mis_cnt_c),
    .state(state)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       q_vote;
    logic       valid;
    logic       mm;
    logic [2:0] fail;
    logic [7:0] ca, cb, cc;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  logic       m_vote = 1'b0, m_valid = 1'b0, m_mm = 1'b0;
  logic [2:0] m_fail = 3'b000;
  int         m_cnt[3] = '{0, 0, 0};
  int         m_con[3] = '{0, 0, 0};
  int         m_split = 0;
  int         m_st = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_mis++;
      $display("FAIL %s cycle=%0d got=%0h expected=%0h", tag, cyc, obs, exp_v);
    end
  endtask

  task automatic model(input logic r, input logic e, input logic a, input logic b, input logic c);
    logic v[3];
    logic mj, x, y;
    v[0] = a; v[1] = b; v[2] = c;
    mj = (a + b + c) >= 2;
    if (r) begin
      m_vote = 0; m_valid = 0; m_mm = 0; m_fail = 3'b000; m_split = 0; m_st = 0;
      for (int i = 0; i < 3; i++) begin m_cnt[i] = 0; m_con[i] = 0; end
    end else if (!e) begin
      m_valid = 0; m_mm = 0;
    end else if (m_st == 0) begin
      m_vote = mj; m_valid = 1; m_mm = 0;
      for (int i = 0; i < 3; i++) begin
        if (v[i] != mj) begin
          m_mm = 1;
          m_cnt[i] = (m_cnt[i] < 255) ? m_cnt[i] + 1 : 255;
          m_con[i]++;
          if (m_con[i] == 3) begin m_fail[i] = 1; m_st = 1; end
        end else m_con[i] = 0;
      end
    end else if (m_st == 1) begin
      if (m_fail[0])      begin x = b; y = c; end
      else if (m_fail[1]) begin x = a; y = c; end
      else                begin x = a; y = b; end
      m_valid = 1;
      if (x == y) begin m_vote = x; m_split = 0; m_mm = 0; end
      else begin
        m_mm = 1; m_split++;
        if (m_split == 3) m_st = 2;
      end
    end else begin
      m_valid = 0; m_mm = 1;
    end
  endtask

  task automatic compare();
    exp_t ex;
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
      return;
    end
    ex = sb.pop_front();
    check("q_vote",       q_vote,       ex.q_vote);
    check("valid",        valid,        ex.valid);
    check("any_mismatch", any_mismatch, ex.mm);
    check("lane_fail",    lane_fail,    ex.fail);
    check("mis_cnt_a",    mis_cnt_a,    ex.ca);
    check("mis_cnt_b",    mis_cnt_b,    ex.cb);
    check("mis_cnt_c",    mis_cnt_c,    ex.cc);
    check("state",        state,        ex.st);
  endtask

  task automatic step(input logic r, input logic e, input logic a, input logic b, input logic c);
    exp_t ex;
    @(negedge clk);
    reset = r; en = e; q_a = a; q_b = b; q_c = c;
    model(r, e, a, b, c);
    ex.q_vote = m_vote; ex.valid = m_valid; ex.mm = m_mm; ex.fail = m_fail;
    ex.ca = 8'(m_cnt[0]); ex.cb = 8'(m_cnt[1]); ex.cc = 8'(m_cnt[2]);
    ex.st = 2'(m_st);
    sb.push_back(ex);
    @(posedge clk);
    cyc++;
    #1;
    compare();
  endtask

  initial begin
    logic pat[4];
    pat[0] = 0; pat[1] = 1; pat[2] = 1; pat[3] = 0;

    // Reset, then all lanes agree on a toggling pattern
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, pat[i], pat[i], pat[i]);

    // Lane b inverted for two cycles, then agrees
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1);

    // Lane c disagrees three cycles -> fault, DEGRADED
    for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 1);

    // Healthy pair a/b splits for two cycles, then agrees, then splits to FAILED
    step(0, 1, 1, 0, 0);
    step(0, 1, 1, 0, 1);
    step(0, 1, 1, 1, 0);
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1);
    step(0, 1, 0, 0, 0);
    step(0, 1, 1, 1, 1);

    // Reset, then lane a disagrees 2 cycles / agrees 1, 130 times; en drops mid-pattern
    step(1, 1, 0, 0, 0);
    for (int k = 0; k < 130; k++) begin
      step(0, 1, 1, 0, 0);
      if (k == 60) repeat (3) step(0, 0, 1, 0, 0);
      step(0, 1, 1, 0, 0);
      step(0, 1, 0, 0, 0);
    end

    // Lane b faults with counts nonzero, then reset mid-operation and resume
    for (int i = 0; i < 3; i++) step(0, 1, 1, 0, 1);
    step(1, 1, 1, 0, 1);
    step(0, 1, 1, 1, 1);
    step(0, 1, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout cycle=%0d got=running expected=finished", cyc);
    $fatal(1, "timeout");
  end

endmodule
